// File: rtl/xup_keystream_lfsr_if.sv
// Keystream handshake bundle: control inputs (advance enable, seed load,
// consumer ready) and the keystream word with its valid flag.
// The optional word counter exists only when XUP_KEYSTREAM_WORDCNT_EN is defined.
interface xup_keystream_lfsr_if #(
    parameter int SIZE   = 4,
    parameter int LFSR_W = 16
);
    logic              en;
    logic              load;
    logic [LFSR_W-1:0] seed;
    logic              out_ready;
    logic              out_valid;
    logic [SIZE-1:0]   key;
`ifdef XUP_KEYSTREAM_WORDCNT_EN
    logic [15:0]       word_count;
`endif

    // Consumer / controller side
    modport master (
        output en, load, seed, out_ready,
        input  out_valid, key
`ifdef XUP_KEYSTREAM_WORDCNT_EN
        , input word_count
`endif
    );

    // Keystream generator side
    modport slave (
        input  en, load, seed, out_ready,
        output out_valid, key
`ifdef XUP_KEYSTREAM_WORDCNT_EN
        , output word_count
`endif
    );
endinterface

// File: rtl/xup_keystream_lfsr.sv
// Fibonacci-LFSR keystream generator feeding the b operand of the XOR vector
// stage. One LFSR bit per enabled clock is packed MSB-first into a SIZE-bit
// word; the finished word is held on a valid/ready handshake until consumed.
// Optional feature macro: XUP_KEYSTREAM_WORDCNT_EN (adds a 16-bit count of
// consumed words, cleared by reset and by load).
module xup_keystream_lfsr #(
    parameter int                SIZE       = 4,
    parameter int                LFSR_W     = 16,
    parameter logic [LFSR_W-1:0] TAPS       = 16'hB400,
    parameter logic [LFSR_W-1:0] RESET_SEED = 16'hACE1
) (
    input logic                  clk,
    input logic                  reset_n,
    xup_keystream_lfsr_if.slave  ks
);

    localparam int CNT_W = $clog2(SIZE + 1);

    typedef enum logic [0:0] {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t            state_q;
    logic [LFSR_W-1:0] lfsr_q;
    logic [SIZE-1:0]   key_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              valid_q;

    logic              out_bit;
    logic              fb;
    logic [LFSR_W:0]   lfsr_ext;
    logic [SIZE:0]     key_ext;
    logic [LFSR_W-1:0] lfsr_d;
    logic [SIZE-1:0]   key_d;
    logic [LFSR_W-1:0] seed_d;
    logic              last_bit;
    logic              handshake;

    // Next shift values; widened concatenation keeps SIZE=1 legal
    always_comb begin
        out_bit  = lfsr_q[LFSR_W-1];
        fb       = ^(lfsr_q & TAPS);
        lfsr_ext = {lfsr_q, fb};
        lfsr_d   = lfsr_ext[LFSR_W-1:0];
        key_ext  = {key_q, out_bit};
        key_d    = key_ext[SIZE-1:0];
        // An all-zero seed would lock the LFSR, so it is replaced by 1
        seed_d   = (ks.seed == '0) ? LFSR_W'(1) : ks.seed;
        last_bit = (cnt_q == CNT_W'(SIZE - 1));
        handshake = valid_q & ks.out_ready;
    end

    // Fill/hold controller; load overrides everything, including a handshake
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= FILL;
            lfsr_q  <= RESET_SEED;
            key_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else if (ks.load) begin
            state_q <= FILL;
            lfsr_q  <= seed_d;
            key_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                FILL: begin
                    if (ks.en) begin
                        lfsr_q <= lfsr_d;
                        key_q  <= key_d;
                        if (last_bit) begin
                            cnt_q   <= '0;
                            valid_q <= 1'b1;
                            state_q <= HOLD;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                HOLD: begin
                    // LFSR and key frozen; en has no effect here
                    if (handshake) begin
                        valid_q <= 1'b0;
                        state_q <= FILL;
                    end
                end
                default: begin
                    state_q <= FILL;
                    valid_q <= 1'b0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign ks.out_valid = valid_q;
    assign ks.key       = key_q;

`ifdef XUP_KEYSTREAM_WORDCNT_EN
    logic [15:0] wcnt_q;

    // Consumed-word counter; load wins over a same-cycle handshake
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wcnt_q <= '0;
        end else if (ks.load) begin
            wcnt_q <= '0;
        end else if (handshake) begin
            wcnt_q <= wcnt_q + 16'd1;
        end
    end

    assign ks.word_count = wcnt_q;
`endif

endmodule

// File: tb/tb_xup_keystream_lfsr.sv
// Self-checking bench for xup_keystream_lfsr: directed scenarios plus a
// randomized run, all compared against a bit-stream reference model.
module tb_xup_keystream_lfsr;
    localparam int          SIZE   = 4;
    localparam int          LFSR_W = 16;
    localparam logic [15:0] TAPS   = 16'hB400;
    localparam logic [15:0] SEED0  = 16'hACE1;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    xup_keystream_lfsr_if #(.SIZE(SIZE), .LFSR_W(LFSR_W)) ks_if ();

    xup_keystream_lfsr #(
        .SIZE(SIZE), .LFSR_W(LFSR_W), .TAPS(TAPS), .RESET_SEED(SEED0)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .ks(ks_if)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // Reference model: a generator of LFSR bits plus a collector of SIZE bits
    logic [15:0]     m_lfsr;
    logic [SIZE-1:0] m_key;
    logic            m_valid;
    int              m_bits;
    logic [15:0]     m_wc;

    task automatic model_reset();
        m_lfsr = SEED0; m_key = '0; m_valid = 1'b0; m_bits = 0; m_wc = '0;
    endtask

    task automatic model_step(input logic e, input logic l, input logic [15:0] s, input logic r);
        logic ob, fbit;
        if (l) begin
            m_lfsr = (s == 16'h0) ? 16'h0001 : s;
            m_key = '0; m_bits = 0; m_valid = 1'b0; m_wc = '0;
        end else if (m_valid) begin
            if (r) begin m_valid = 1'b0; m_wc = m_wc + 16'd1; end
        end else if (e) begin
            ob = m_lfsr[15];
            fbit = ($countones(m_lfsr & TAPS) % 2) == 1;
            m_lfsr = {m_lfsr[14:0], fbit};
            m_key = {m_key[SIZE-2:0], ob};
            m_bits++;
            if (m_bits == SIZE) begin m_valid = 1'b1; m_bits = 0; end
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".valid"}, {31'd0, ks_if.out_valid}, {31'd0, m_valid});
        chk({tag, ".key"}, {28'd0, ks_if.key}, {28'd0, m_key});
`ifdef XUP_KEYSTREAM_WORDCNT_EN
        chk({tag, ".wcnt"}, {16'd0, ks_if.word_count}, {16'd0, m_wc});
`endif
    endtask

    // One clock: drive inputs, advance model at the edge, compare 1ns later
    task automatic tick(input logic e, input logic l, input logic [15:0] s, input logic r, input string tag);
        ks_if.en = e; ks_if.load = l; ks_if.seed = s; ks_if.out_ready = r;
        @(posedge clk);
        model_step(e, l, s, r);
        #1;
        check_model(tag);
    endtask

    // Run with en=1 until out_valid, bounded; returns number of clocks used
    task automatic run_to_valid(input logic r, input string tag, output int n);
        n = 0;
        do begin
            tick(1'b1, 1'b0, 16'h0, r, tag);
            n++;
        end while (!ks_if.out_valid && n < 40);
        if (!ks_if.out_valid) chk({tag, ".timeout"}, 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        ks_if.en = 1'b0; ks_if.load = 1'b0; ks_if.seed = '0; ks_if.out_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #3;
        check_model("rst");
        reset_n = 1'b1;
    endtask

    int n, cyc, first, prev;
    logic [SIZE-1:0] words [4];
    logic [15:0] s;

    initial begin
        do_reset();

        // Default sequence: words A, C, E, 1; first valid 4 clocks in, then every 5
        begin
            int k;
            k = 0; cyc = 0; first = 0; prev = 0;
            while (k < 4 && cyc < 40) begin
                tick(1'b1, 1'b0, 16'h0, 1'b1, "seq");
                cyc++;
                if (ks_if.out_valid) begin
                    words[k] = ks_if.key;
                    if (k == 0) first = cyc;
                    else chk("seq.gap", cyc - prev, 5);
                    prev = cyc;
                    k++;
                end
            end
            chk("seq.first", first, 4);
            chk("seq.w0", {28'd0, words[0]}, 32'hA);
            chk("seq.w1", {28'd0, words[1]}, 32'hC);
            chk("seq.w2", {28'd0, words[2]}, 32'hE);
            chk("seq.w3", {28'd0, words[3]}, 32'h1);
        end

        // Backpressure: word held for 10 stalled clocks, next word is C
        do_reset();
        run_to_valid(1'b0, "bp", n);
        for (int i = 0; i < 10; i++) begin
            tick(1'b1, 1'b0, 16'h0, 1'b0, "bp.stall");
            chk("bp.key", {28'd0, ks_if.key}, 32'hA);
            chk("bp.valid", {31'd0, ks_if.out_valid}, 32'd1);
        end
        tick(1'b1, 1'b0, 16'h0, 1'b1, "bp.hs");
        chk("bp.drop", {31'd0, ks_if.out_valid}, 32'd0);
        run_to_valid(1'b0, "bp.next", n);
        chk("bp.w1", {28'd0, ks_if.key}, 32'hC);

        // en pattern 1,0,0,1,1,1: valid only after the fourth enabled clock
        do_reset();
        begin
            logic [5:0] pat;
            pat = 6'b111001;  // applied LSB first
            for (int i = 0; i < 6; i++) begin
                tick(pat[i], 1'b0, 16'h0, 1'b0, "en");
                chk("en.valid", {31'd0, ks_if.out_valid}, (i == 5) ? 32'd1 : 32'd0);
            end
            chk("en.word", {28'd0, ks_if.key}, 32'hA);
        end

        // Zero-seed load mid-fill: LFSR becomes 1, so the set bit is the
        // sixteenth output bit -> words 0,0,0,1
        do_reset();
        tick(1'b1, 1'b0, 16'h0, 1'b1, "z.pre");
        tick(1'b1, 1'b0, 16'h0, 1'b1, "z.pre");
        tick(1'b1, 1'b1, 16'h0000, 1'b1, "z.load");
        chk("z.lfsr", {16'd0, dut.lfsr_q}, 32'h0001);
        for (int i = 0; i < 4; i++) begin
            run_to_valid(1'b1, "z.run", n);
            chk("z.word", {28'd0, ks_if.key}, (i == 3) ? 32'h1 : 32'h0);
        end

        // Load coincident with a hold handshake
        do_reset();
        run_to_valid(1'b1, "lh", n);
        tick(1'b1, 1'b1, 16'h5A3C, 1'b1, "lh.load");
        chk("lh.valid", {31'd0, ks_if.out_valid}, 32'd0);
`ifdef XUP_KEYSTREAM_WORDCNT_EN
        chk("lh.wcnt", {16'd0, ks_if.word_count}, 32'd0);
`endif
        run_to_valid(1'b1, "lh.run", n);
        chk("lh.word", {28'd0, ks_if.key}, 32'h5);

        // Asynchronous reset mid-hold, away from any clock edge
        run_to_valid(1'b0, "ar", n);
        tick(1'b1, 1'b0, 16'h0, 1'b0, "ar.hold");
        #2 reset_n = 1'b0;
        #1;
        chk("ar.valid", {31'd0, ks_if.out_valid}, 32'd0);
        chk("ar.key", {28'd0, ks_if.key}, 32'd0);
        model_reset();
        #3 reset_n = 1'b1;
        run_to_valid(1'b1, "ar.run", n);
        chk("ar.lat", n, 4);
        chk("ar.word", {28'd0, ks_if.key}, 32'hA);

        // Randomized run against the model
        for (int i = 0; i < 600; i++) begin
            s = 16'($urandom);
            if ($urandom_range(0, 7) == 0) s = 16'h0;
            tick(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 29) == 0), s,
                 1'($urandom_range(0, 2) != 0), "rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
